uart_transmitter_controller: RTL
================================

UART_TRANSMITTER_CONTROLLER -- requirements
Module: uart_transmitter_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning UART frame / register-file data width.
REQ-002 SHALL have parameter ALU_RESULT_WIDTH, default 2*DATA_WIDTH, meaning ALU result width; it is always exactly 2*DATA_WIDTH.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  capture enable for new results.
REQ-006 ALU_result  input  ALU_RESULT_WIDTH  ALU output word.
REQ-007 ALU_result_valid  input  1  single-cycle pulse, ALU_result valid.
REQ-008 read_data  input  DATA_WIDTH  register-file read data.
REQ-009 read_data_valid  input  1  single-cycle pulse, read_data valid.
REQ-010 fifo_full  input  1  TX FIFO full, backpressure.
REQ-011 fifo_write_enable  output  1  push one byte into the TX FIFO this cycle.
REQ-012 fifo_write_data  output  DATA_WIDTH  byte pushed with fifo_write_enable.
REQ-013 busy  output  1  high while any result is pending or being sent.
REQ-014 overflow  output  1  sticky flag, a result was dropped.

Function
REQ-015 Two holding slots SHALL exist: read slot (DATA_WIDTH data + pending bit) and ALU slot (ALU_RESULT_WIDTH data + pending bit).
REQ-016 A valid pulse sampled with enable=1 SHALL load its slot and set its pending bit at that edge if the pending bit is clear, or if it clears in the same cycle.
REQ-017 A valid pulse sampled with enable=1 while its slot stays pending SHALL be dropped and SHALL set overflow at that edge; slot contents SHALL be unchanged.
REQ-018 Valid pulses with enable=0 SHALL be ignored, without capture and without setting overflow; transfers in progress SHALL complete regardless of enable.
REQ-019 Simultaneous ALU_result_valid and read_data_valid SHALL load both slots.
REQ-020 The FSM SHALL have four states: IDLE, SEND_READ, SEND_ALU_LOW and SEND_ALU_HIGH.
REQ-021 IDLE SHALL go to SEND_ALU_LOW if the ALU slot is pending, else to SEND_READ if the read slot is pending, else stay in IDLE; the ALU slot has priority.
REQ-022 In every SEND state, fifo_write_enable SHALL equal ~fifo_full; the state SHALL advance only on a cycle with fifo_write_enable=1, otherwise it holds.
REQ-023 SEND_READ SHALL drive the read-slot byte; on write it SHALL clear the read pending bit and go to IDLE.
REQ-024 SEND_ALU_LOW SHALL drive ALU slot bits [DATA_WIDTH-1:0]; on write it SHALL go to SEND_ALU_HIGH.
REQ-025 SEND_ALU_HIGH SHALL drive ALU slot bits [ALU_RESULT_WIDTH-1:DATA_WIDTH]; on write it SHALL clear the ALU pending bit and go to IDLE.
REQ-026 Latency: with fifo_full=0, the first fifo_write_enable SHALL occur in the second cycle after the cycle that samples valid, i.e. edge k captures, edge k+1 enters the SEND state, and the write is in cycle k+1..k+2.
REQ-027 The low and high bytes of one ALU result SHALL always be written in consecutive FIFO pushes; a read byte SHALL never be interleaved between them.
REQ-028 fifo_write_data SHALL be all-zero whenever fifo_write_enable=0.
REQ-029 busy SHALL be combinational: (state != IDLE) OR either pending bit set.

Reset
REQ-030 While reset=0, the state SHALL be IDLE, both pending bits 0, both slots 0, overflow 0, fifo_write_enable 0, fifo_write_data 0 and busy 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer, so the high byte of a half-sent ALU result is never sent; overflow SHALL clear only on reset.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'b00, SEND_READ=2'b01, SEND_ALU_LOW=2'b10, SEND_ALU_HIGH=2'b11) and the DATA_WIDTH default.
REQ-033 One sub-module tx_holding_slot SHALL be used, parameterized by width, implementing the data register, pending bit, load/clear and drop detection; it SHALL be instantiated twice.

Verification
REQ-034 read_data=8'h5A with valid, fifo_full=0 -> one push of 8'h5A two cycles later; busy then falls to 0.
REQ-035 ALU_result=16'hBEEF with valid -> pushes 8'hEF then 8'hBE on consecutive cycles.
REQ-036 Same-cycle ALU 16'h1234 and read 8'h77 -> push order 8'h34, 8'h12, 8'h77.
REQ-037 fifo_full held 1 for 5 cycles during SEND_ALU_HIGH of 16'hA0B1 -> 8'hA0 held with no push, pushed once fifo_full=0; no duplicate push.
REQ-038 Second read valid 8'h22 while 8'h11 is still pending under fifo_full=1 -> overflow=1, only 8'h11 sent; reading with enable=0 -> nothing captured.
REQ-039 reset asserted after the low byte of 16'hCAFE is pushed -> no 8'hCA push; all outputs 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/uart_transmitter_controller_pkg.sv
// Shared types for the UART transmit controller.
// Holds the FSM state encoding and the default frame width.
package uart_transmitter_controller_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    SEND_READ     = 2'b01,
    SEND_ALU_LOW  = 2'b10,
    SEND_ALU_HIGH = 2'b11
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_controller_tx_holding_slot.sv
// One result holding slot: data register, pending bit,
// load/clear handling and drop detection.
module tx_holding_slot
  import uart_transmitter_controller_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pending,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_data;
  logic             r_pending;
  logic             w_accept;

  // A slot freed on this edge may be refilled on the same edge.
  assign w_accept  = i_load & (~r_pending | i_clear);
  assign o_drop    = i_load & r_pending & ~i_clear;
  assign o_data    = r_data;
  assign o_pending = r_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_data    <= i_data;
      r_pending <= 1'b1;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_transmitter_controller.sv
// Serialises ALU results and register reads into the TX FIFO.
// ALU words go out low byte then high byte, never split.
module uart_transmitter_controller
  import uart_transmitter_controller_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int ALU_RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [ALU_RESULT_WIDTH-1:0] ALU_result,
  input  logic                        ALU_result_valid,
  input  logic [DATA_WIDTH-1:0]       read_data,
  input  logic                        read_data_valid,
  input  logic                        fifo_full,
  output logic                        fifo_write_enable,
  output logic [DATA_WIDTH-1:0]       fifo_write_data,
  output logic                        busy,
  output logic                        overflow
);

  tx_state_e r_state;
  tx_state_e w_state_nxt;
  logic      r_overflow;

  logic                        w_rd_load;
  logic                        w_rd_clr;
  logic                        w_rd_pend;
  logic                        w_rd_drop;
  logic [DATA_WIDTH-1:0]       w_rd_data;

  logic                        w_alu_load;
  logic                        w_alu_clr;
  logic                        w_alu_pend;
  logic                        w_alu_drop;
  logic [ALU_RESULT_WIDTH-1:0] w_alu_data;

  logic                        w_we;
  logic [DATA_WIDTH-1:0]       w_wdata;

  assign w_rd_load  = read_data_valid & enable;
  assign w_alu_load = ALU_result_valid & enable;
  assign w_rd_clr   = (r_state == SEND_READ) & ~fifo_full;
  assign w_alu_clr  = (r_state == SEND_ALU_HIGH) & ~fifo_full;

  tx_holding_slot #(
    .WIDTH (DATA_WIDTH)
  ) u_read_slot (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_rd_load),
    .i_data    (read_data),
    .i_clear   (w_rd_clr),
    .o_data    (w_rd_data),
    .o_pending (w_rd_pend),
    .o_drop    (w_rd_drop)
  );

  tx_holding_slot #(
    .WIDTH (ALU_RESULT_WIDTH)
  ) u_alu_slot (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_alu_load),
    .i_data    (ALU_result),
    .i_clear   (w_alu_clr),
    .o_data    (w_alu_data),
    .o_pending (w_alu_pend),
    .o_drop    (w_alu_drop)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_alu_pend) begin
          w_state_nxt = SEND_ALU_LOW;
        end else if (w_rd_pend) begin
          w_state_nxt = SEND_READ;
        end
      end
      SEND_READ: begin
        w_we = ~fifo_full;
        if (w_we) begin
          w_wdata     = w_rd_data;
          w_state_nxt = IDLE;
        end
      end
      SEND_ALU_LOW: begin
        w_we = ~fifo_full;
        if (w_we) begin
          w_wdata     = w_alu_data[DATA_WIDTH-1:0];
          w_state_nxt = SEND_ALU_HIGH;
        end
      end
      SEND_ALU_HIGH: begin
        w_we = ~fifo_full;
        if (w_we) begin
          w_wdata     = w_alu_data[ALU_RESULT_WIDTH-1:DATA_WIDTH];
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sticky until reset; only a dropped result sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_rd_drop | w_alu_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign fifo_write_enable = w_we;
  assign fifo_write_data   = w_wdata;
  assign overflow          = r_overflow;
  assign busy = (r_state != IDLE) | w_rd_pend | w_alu_pend;

endmodule
